// File: rtl/device_io_hub_if.sv
// device_io_hub_if: groups the cluster device bus and the buffered output
// channel used by device_io_hub.
//   master : cluster/host side; drives device_* requests and out_ready,
//            receives device_data_in and the output FIFO head.
//   slave  : device_io_hub side.
interface device_io_hub_if #(
  parameter int unsigned NUM_CORES = 16
) ();
  localparam int unsigned CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic [CW-1:0] device_core_id;
  logic          device_write_en;
  logic          device_read_en;
  logic [9:0]    device_addr;
  logic [15:0]   device_data_out;
  logic [15:0]   device_data_in;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] out_core_id;
  logic [15:0]   out_data;

  modport master (
    output device_core_id, device_write_en, device_read_en, device_addr,
           device_data_out, out_ready,
    input  device_data_in, out_valid, out_core_id, out_data
  );

  modport slave (
    input  device_core_id, device_write_en, device_read_en, device_addr,
           device_data_out, out_ready,
    output device_data_in, out_valid, out_core_id, out_data
  );
endinterface

// File: rtl/device_io_hub.sv
// device_io_hub: memory-mapped device block on the cluster device bus.
//   - NUM_MUTEXES owner-checked hardware mutexes (0x3fe downwards)
//   - output FIFO (push at 0x3ff) drained over a valid/ready handshake
//   - status register at 0x3f0: {sticky overflow, occupancy}, clear-on-read
// Ports:
//   clk      : clock
//   reset_n  : asynchronous active-low reset
//   bus      : device_io_hub_if slave modport (device bus + output channel)
module device_io_hub #(
  parameter int unsigned NUM_CORES      = 16,
  parameter int unsigned NUM_MUTEXES    = 2,
  parameter int unsigned OUT_FIFO_DEPTH = 8
) (
  input  logic           clk,
  input  logic           reset_n,
  device_io_hub_if.slave bus
);
  localparam int unsigned CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned PW = $clog2(OUT_FIFO_DEPTH);

  localparam logic [9:0]  ADDR_PUSH   = 10'h3ff;
  localparam logic [9:0]  ADDR_MUTEX0 = 10'h3fe;
  localparam logic [9:0]  ADDR_STATUS = 10'h3f0;
  localparam logic [PW:0] FULL_COUNT  = OUT_FIFO_DEPTH[PW:0];

  logic                   wr_access;
  logic                   rd_access;
  logic                   push_req;
  logic                   push_ok;
  logic                   pop;
  logic                   status_rd;
  logic                   fifo_valid;

  logic [NUM_MUTEXES-1:0] mutex_sel;
  logic [NUM_MUTEXES-1:0] mutex_held;
  logic [CW-1:0]          mutex_holder [NUM_MUTEXES];

  logic [CW-1:0]          fifo_id   [OUT_FIFO_DEPTH];
  logic [15:0]            fifo_data [OUT_FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr;
  logic [PW-1:0]          rd_ptr;
  logic [PW:0]            count;
  logic                   overflow;

  logic                   rd_hit;
  logic [15:0]            rd_value;
  logic [15:0]            rd_data_q;

  // Write has priority: a read issued together with a write is dropped.
  assign wr_access  = bus.device_write_en;
  assign rd_access  = bus.device_read_en && !bus.device_write_en;
  assign push_req   = wr_access && (bus.device_addr == ADDR_PUSH);
  assign status_rd  = rd_access && (bus.device_addr == ADDR_STATUS);
  assign fifo_valid = (count != '0);
  assign pop        = fifo_valid && bus.out_ready;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok    = push_req && ((count != FULL_COUNT) || pop);

  always_comb begin
    mutex_sel = '0;
    for (int unsigned i = 0; i < NUM_MUTEXES; i++) begin
      mutex_sel[i] = (bus.device_addr == (ADDR_MUTEX0 - 10'(i)));
    end
  end

  always_comb begin
    rd_hit   = 1'b0;
    rd_value = '0;
    if (bus.device_addr == ADDR_STATUS) begin
      rd_hit   = 1'b1;
      rd_value = {overflow, 15'(count)};
    end
    for (int unsigned i = 0; i < NUM_MUTEXES; i++) begin
      if (mutex_sel[i]) begin
        rd_hit   = 1'b1;
        rd_value = {15'd0, mutex_held[i] && (mutex_holder[i] == bus.device_core_id)};
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mutex_held <= '0;
      for (int unsigned i = 0; i < NUM_MUTEXES; i++) begin
        mutex_holder[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_MUTEXES; i++) begin
        if (wr_access && mutex_sel[i]) begin
          if (bus.device_data_out != 16'd0) begin
            if (!mutex_held[i]) begin
              mutex_held[i]   <= 1'b1;
              mutex_holder[i] <= bus.device_core_id;
            end
          end else if (mutex_held[i] && (mutex_holder[i] == bus.device_core_id)) begin
            mutex_held[i] <= 1'b0;
          end
        end
      end
    end
  end

  // Storage needs no reset: the head is only exposed while count != 0.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_id[wr_ptr]   <= bus.device_core_id;
      fifo_data[wr_ptr] <= bus.device_data_out;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      // A dropped push and a status read cannot coincide (write wins).
      if (push_req && !push_ok) begin
        overflow <= 1'b1;
      end else if (status_rd) begin
        overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_q <= '0;
    end else if (rd_access && rd_hit) begin
      rd_data_q <= rd_value;
    end
  end

  assign bus.device_data_in = rd_data_q;
  assign bus.out_valid      = fifo_valid;
  assign bus.out_core_id    = fifo_valid ? fifo_id[rd_ptr] : '0;
  assign bus.out_data       = fifo_valid ? fifo_data[rd_ptr] : '0;
endmodule

// File: doc/device_io_hub.md
Name: device_io_hub

Overview:
Parametrised memory-mapped device block that sits on the cluster device bus (`device_*` signals) beside the cluster.
- Provides NUM_MUTEXES hardware mutexes with owner-checked acquire and release.
- Provides a buffered output channel: a FIFO with a valid/ready handshake to the host, replacing the unbuffered single-cycle output strobe.
- Provides a status register reporting FIFO occupancy and a sticky overflow flag.

Parameters:
- NUM_CORES, 16, number of cores; core ID width is CW = $clog2(NUM_CORES).
- NUM_MUTEXES, 2, number of mutexes; legal range 1..14.
- OUT_FIFO_DEPTH, 8, output FIFO entries; must be a power of 2 and at least 2.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- device_core_id  in  CW  ID of the core making the current access.
- device_write_en  in  1  device write strobe.
- device_read_en  in  1  device read strobe.
- device_addr  in  10  device address.
- device_data_out  in  16  write data from the cluster.
- device_data_in  out  16  registered read data to the cluster.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  host accepts the FIFO head.
- out_core_id  out  CW  core ID of the FIFO head entry.
- out_data  out  16  data of the FIFO head entry.

Behaviour:
- Reset (reset_n low, asynchronous): device_data_in=0, all mutexes free with holder=0, FIFO empty, out_valid=0, out_core_id=0, out_data=0, overflow=0.
- Bus: at most one of device_write_en/device_read_en is high per cycle. If both are high, the write wins and the read is ignored.
- Address map:
  - 0x3ff: output FIFO push (write only).
  - 0x3fe-i, for i=0..NUM_MUTEXES-1: mutex i.
  - 0x3f0: status.
  - All other addresses: no effect.
- Read latency: device_data_in updates on the clock edge after a read of a mapped address. It holds its value until the next mapped read. Reads of unmapped addresses and of 0x3ff leave it unchanged.
- Mutex i, write with data != 0:
  - Mutex free: held=1, holder=device_core_id.
  - Mutex held (by any core): no change.
- Mutex i, write with data == 0:
  - Issued by the holder while held: held=0.
  - Issued by a non-holder, or while the mutex is free: ignored; holder is unchanged.
- Mutex i, read: returns 16'd1 if held && holder==device_core_id, else 16'd0.
- FIFO push (write to 0x3ff): entry is {device_core_id, device_data_out}.
  - Accepted when count<DEPTH, or when count==DEPTH and a pop happens the same cycle.
  - Otherwise the entry is dropped and overflow is set to 1 (sticky).
- FIFO pop: occurs when out_valid && out_ready at a clock edge.
- out_valid = (count != 0). out_core_id and out_data show the head entry combinationally from registered storage. They are held stable while out_valid && !out_ready.
- A push into an empty FIFO makes out_valid=1 on the next cycle (1-cycle latency), not in the same cycle.
- Push and pop in the same cycle: count is unchanged and FIFO order is preserved.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits and ranges 0..DEPTH.
- Status read (0x3f0): returns {overflow, 15'(count)}, i.e. overflow in bit 15 and count zero-extended in the low bits.
  - The read clears overflow on the same edge.
  - The returned value is the pre-clear value.
  - Writes to 0x3f0 are ignored.
- Reset asserted mid-operation: FIFO contents are discarded and every mutex is released immediately. No partial handshake survives: out_valid drops asynchronously.

Test Plan:
- Reset, then core 3 writes 1 to 0x3fe and reads 0x3fe -> device_data_in=1. Core 5 then reads 0x3fe -> 0, writes 1 to 0x3fe -> ignored, reads again -> 0.
- Core 5 writes 0 to 0x3fe while core 3 holds it -> still held. Core 3 writes 0 -> released. Core 5 writes 1 -> device_data_in on its next read of 0x3fe is 1.
- NUM_MUTEXES=4: cores 0..3 each acquire mutex at 0x3fe..0x3fb respectively -> each reads 1 on its own mutex and 0 on the others. A write to 0x3fa has no effect.
- out_ready=0, DEPTH=8: core 2 writes 0x1000..0x1008 (9 writes) to 0x3ff.
  - Status read -> 0x8008, and a second status read -> 0x0008.
  - Then with out_ready=1: 8 entries drain in order 0x1000..0x1007, all with out_core_id=2; 0x1008 is lost.
- With FIFO full and out_ready=1, a push in the same cycle is accepted -> count stays 8 and overflow stays 0.
- 3 entries pending, reset_n pulsed low for 1 cycle -> out_valid=0 and status read -> 0x0000. A previously held mutex now reads 0 for its former holder.
